// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter_if
//  Purpose  : Bundles the loader, reader and RAM-side signals of the RAM
//             arbiter into one interface.
//  Modports : master - arbiter view (drives RAM request, acknowledges clients)
//             slave  - environment view (loader, readers and RAM model)
//  Ports    : init_*   loader write channel
//             rdN_*    two reader channels
//             mem_*    RAM operation channel
//             busy / timeout_err status
//  Revision : 1.0  initial release
// ============================================================================
interface ram_arbiter_if #(
  parameter int AW = 23,
  parameter int DW = 64
);
  // Loader channel
  logic          init_we;
  logic [AW-1:0] init_address;
  logic [DW-1:0] init_data;
  logic          init_done;
  logic          init_op_begun;

  // Reader channels
  logic          rd0_req;
  logic          rd1_req;
  logic [AW-1:0] rd0_address;
  logic [AW-1:0] rd1_address;
  logic [DW-1:0] rd0_data;
  logic [DW-1:0] rd1_data;
  logic          rd0_valid;
  logic          rd1_valid;

  // RAM channel
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_wdata;
  logic          mem_op_begun;
  logic [DW-1:0] mem_rdata;
  logic          mem_rdata_valid;

  // Status
  logic          busy;
  logic          timeout_err;

  modport master (
    input  init_we, init_address, init_data, init_done,
    output init_op_begun,
    input  rd0_req, rd1_req, rd0_address, rd1_address,
    output rd0_data, rd1_data, rd0_valid, rd1_valid,
    output mem_req, mem_we, mem_address, mem_wdata,
    input  mem_op_begun, mem_rdata, mem_rdata_valid,
    output busy, timeout_err
  );

  modport slave (
    output init_we, init_address, init_data, init_done,
    input  init_op_begun,
    output rd0_req, rd1_req, rd0_address, rd1_address,
    input  rd0_data, rd1_data, rd0_valid, rd1_valid,
    input  mem_req, mem_we, mem_address, mem_wdata,
    output mem_op_begun, mem_rdata, mem_rdata_valid,
    input  busy, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Shares one RAM port between a loader (writes, before init_done)
//             and two round-robin readers (after init_done). One operation
//             at a time; any RAM wait longer than TIMEOUT cycles locks the
//             block in a terminal error state until reset.
//  Ports    : clk50  - system clock, rising edge
//             reset  - asynchronous, active-low reset
//             bus    - ram_arbiter_if.master (loader, readers, RAM, status)
//  Revision : 1.0  initial release
// ============================================================================
module ram_arbiter #(
  parameter int AW      = 23,
  parameter int DW      = 64,
  parameter int TIMEOUT = 1023
) (
  input  wire           clk50,
  input  wire           reset,
  ram_arbiter_if.master bus
);

  localparam int            CW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WRITE   = 3'd1,
    S_READ    = 3'd2,
    S_WAIT_RD = 3'd3,
    S_RD_DONE = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t        state_q,    state_d;
  logic          owner_q,    owner_d;     // reader currently served
  logic          last_q,     last_d;      // reader served most recently
  logic [AW-1:0] addr_q,     addr_d;
  logic [DW-1:0] wdata_q,    wdata_d;
  logic [DW-1:0] rd0_data_q, rd0_data_d;
  logic [DW-1:0] rd1_data_q, rd1_data_d;
  logic [CW-1:0] cnt_q,      cnt_d;

  logic          pick_rd1;
  logic          timed_out;
  logic [CW-1:0] cnt_inc;
  logic          op_ack;

  // On a tie the reader that was not served last wins; a lone requester wins.
  assign pick_rd1  = bus.rd1_req && (!bus.rd0_req || !last_q);
  assign timed_out = (cnt_q == C_TIMEOUT);
  assign cnt_inc   = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd0_data_d = rd0_data_q;
    rd1_data_d = rd1_data_q;
    cnt_d      = '0;           // zero on entry to every counted state
    op_ack     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!bus.init_done) begin
          // Loader phase: reader requests stay pending until init_done.
          if (bus.init_we) begin
            addr_d  = bus.init_address;
            wdata_d = bus.init_data;
            state_d = S_WRITE;
          end
        end else if (bus.rd0_req || bus.rd1_req) begin
          owner_d = pick_rd1;
          last_d  = pick_rd1;
          addr_d  = pick_rd1 ? bus.rd1_address : bus.rd0_address;
          state_d = S_READ;
        end
      end

      S_WRITE: begin
        // A RAM acceptance arriving in the same cycle as the timeout wins.
        if (bus.mem_op_begun) begin
          op_ack  = 1'b1;
          state_d = S_IDLE;
        end else if (timed_out) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_READ: begin
        if (bus.mem_op_begun) begin
          state_d = S_WAIT_RD;
        end else if (timed_out) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_WAIT_RD: begin
        if (bus.mem_rdata_valid) begin
          if (owner_q) rd1_data_d = bus.mem_rdata;
          else         rd0_data_d = bus.mem_rdata;
          state_d = S_RD_DONE;
        end else if (timed_out) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_RD_DONE: state_d = S_IDLE;

      S_ERROR:   cnt_d = cnt_q;   // terminal; only reset leaves

      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;   // reader 0 wins the first tie
      addr_q     <= '0;
      wdata_q    <= '0;
      rd0_data_q <= '0;
      rd1_data_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd0_data_q <= rd0_data_d;
      rd1_data_q <= rd1_data_d;
      cnt_q      <= cnt_d;
    end
  end

  // All outputs decode directly from registered state, except the loader
  // acknowledge which must follow mem_op_begun within the same cycle.
  assign bus.mem_req       = (state_q == S_WRITE) || (state_q == S_READ);
  assign bus.mem_we        = (state_q == S_WRITE);
  assign bus.mem_address   = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.init_op_begun = op_ack;
  assign bus.rd0_data      = rd0_data_q;
  assign bus.rd1_data      = rd1_data_q;
  assign bus.rd0_valid     = (state_q == S_RD_DONE) && !owner_q;
  assign bus.rd1_valid     = (state_q == S_RD_DONE) &&  owner_q;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.timeout_err   = (state_q == S_ERROR);

endmodule
`default_nettype wire
